// File: rtl/fft_fsm_pkg.sv
// Shared FFT control types: FSM state encoding, latency counter width and
// a width-parameterised bit-reversal helper.
package fft_fsm_pkg;

  typedef enum logic [3:0] {
    IDLE            = 4'd0,
    ACTIVE_WRITE    = 4'd1,
    READ_1          = 4'd2,
    READ_2          = 4'd3,
    COMPUTE_MUL     = 4'd4,
    COMPUTE_ADD_SUB = 4'd5,
    WRITE_RESULT_1  = 4'd6,
    WRITE_RESULT_2  = 4'd7,
    DONE            = 4'd8,
    READ_RAM        = 4'd9
  } state_fsm;

  // Wide enough for any RAM/multiplier/adder latency this datapath will see.
  localparam int LAT_W      = 8;
  localparam int MAX_ADDR_W = 16;

  // Reverses the low w bits of v; bits at and above w return as zero.
  function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] v,
                                                   input int w);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < w) begin
        r[i] = v[w-1-i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_fft_bfly_addr.sv
// Radix-2 DIT butterfly address math: (stage, bfly) -> top/bottom RAM
// addresses and twiddle ROM index. Purely combinational.
module fft_bfly_addr #(
  parameter int LOG2N = 4
) (
  input  logic [LOG2N-1:0] stage_i,
  input  logic [LOG2N-2:0] bfly_i,
  output logic [LOG2N-1:0] top_o,
  output logic [LOG2N-1:0] bot_o,
  output logic [LOG2N-2:0] tw_o
);

  logic [LOG2N-1:0] w_bfly_ext;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;

  // span = distance between butterfly legs; pos/grp split bfly around it.
  always_comb begin
    w_bfly_ext = {1'b0, bfly_i};
    w_span     = LOG2N'(1) << stage_i;
    w_pos      = w_bfly_ext & (w_span - LOG2N'(1));
    w_grp      = w_bfly_ext >> stage_i;
    top_o      = (w_grp << (stage_i + LOG2N'(1))) | w_pos;
    bot_o      = top_o + w_span;
    tw_o       = (LOG2N-1)'(w_pos << (LOG2N'(LOG2N-1) - stage_i));
  end

endmodule

// File: rtl/fft_addr_gen.sv
// FFT address generator: sequencing counters, RAM addressing, twiddle index
// and phase-end flags returned to the control FSM in the same cycle.
module fft_addr_gen
  import fft_fsm_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int LOG2N    = $clog2(N_POINTS),
  parameter int RD_LAT   = 1,
  parameter int MUL_LAT  = 2,
  parameter int ADD_LAT  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  state_fsm         state_i,
  input  logic             en_cnt_samples_i,
  input  logic             en_cnt_rd_i,
  input  logic             wr_mem_i,
  input  logic [LOG2N-1:0] host_addr_i,
  output logic [LOG2N-1:0] ram_addr_o,
  output logic             ram_we_o,
  output logic             res_sel_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic [LOG2N-1:0] stage_o,
  output logic [LOG2N-2:0] bfly_o,
  output logic             end_samples_o,
  output logic             end_read_1_o,
  output logic             end_read_2_o,
  output logic             end_compute_mul_o,
  output logic             end_compute_o,
  output logic             end_write_1_o,
  output logic             end_algo_o
);

  localparam int BW = LOG2N - 1;

  logic [LOG2N-1:0] r_s_cnt;
  logic [LOG2N-1:0] r_stage;
  logic [BW-1:0]    r_bfly;
  logic [LAT_W-1:0] r_wcnt;
  state_fsm         r_state_q;
  logic             r_armed;

  logic [LAT_W-1:0] w_wcnt;
  logic [LOG2N-1:0] w_top;
  logic [LOG2N-1:0] w_bot;
  logic [BW-1:0]    w_tw;
  logic [LOG2N-1:0] w_srev;
  logic             w_last_bfly;
  logic             w_last_stage;

  fft_bfly_addr #(.LOG2N(LOG2N)) u_bfly_addr (
    .stage_i (r_stage),
    .bfly_i  (r_bfly),
    .top_o   (w_top),
    .bot_o   (w_bot),
    .tw_o    (w_tw)
  );

  // The first cycle of a new state must already see a zero wait count.
  assign w_wcnt       = (state_i != r_state_q) ? '0 : r_wcnt;
  assign w_last_bfly  = (r_bfly == BW'(N_POINTS/2 - 1));
  assign w_last_stage = (r_stage == LOG2N'(LOG2N - 1));
  assign w_srev       = LOG2N'(bitrev(MAX_ADDR_W'(r_s_cnt), LOG2N));

  // Sample, stage and butterfly counters plus the per-state wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s_cnt   <= '0;
      r_stage   <= '0;
      r_bfly    <= '0;
      r_wcnt    <= '0;
      r_state_q <= IDLE;
      r_armed   <= 1'b0;
    end else begin
      r_state_q <= state_i;
      r_wcnt    <= (&w_wcnt) ? w_wcnt : w_wcnt + LAT_W'(1);
      case (state_i)
        IDLE, DONE: begin
          r_s_cnt <= '0;
          r_stage <= '0;
          r_bfly  <= '0;
          r_armed <= 1'b0;
        end
        ACTIVE_WRITE: begin
          if (en_cnt_samples_i) r_s_cnt <= r_s_cnt + LOG2N'(1);
        end
        WRITE_RESULT_1: begin
          if (en_cnt_rd_i) r_armed <= 1'b1;
        end
        WRITE_RESULT_2: begin
          // Only a butterfly committed in WRITE_RESULT_1 may advance.
          if (r_armed) begin
            r_armed <= 1'b0;
            r_bfly  <= r_bfly + BW'(1);
            if (w_last_bfly) r_stage <= w_last_stage ? '0 : r_stage + LOG2N'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Same-cycle decode of addresses, enables and phase-end flags.
  always_comb begin
    ram_addr_o        = '0;
    ram_we_o          = 1'b0;
    res_sel_o         = 1'b0;
    tw_addr_o         = '0;
    stage_o           = r_stage;
    bfly_o            = r_bfly;
    end_samples_o     = 1'b0;
    end_read_1_o      = 1'b0;
    end_read_2_o      = 1'b0;
    end_compute_mul_o = 1'b0;
    end_compute_o     = 1'b0;
    end_write_1_o     = 1'b0;
    end_algo_o        = 1'b0;
    case (state_i)
      IDLE, DONE: begin
        ram_addr_o = '0;
      end
      READ_RAM: begin
        ram_addr_o = host_addr_i;
      end
      ACTIVE_WRITE: begin
        ram_addr_o    = w_srev;
        ram_we_o      = wr_mem_i;
        end_samples_o = en_cnt_samples_i && (r_s_cnt == LOG2N'(N_POINTS - 1));
      end
      READ_1: begin
        ram_addr_o   = w_top;
        tw_addr_o    = w_tw;
        end_read_1_o = (w_wcnt == LAT_W'(RD_LAT));
      end
      READ_2: begin
        ram_addr_o   = w_bot;
        tw_addr_o    = w_tw;
        end_read_2_o = (w_wcnt == LAT_W'(RD_LAT));
      end
      COMPUTE_MUL: begin
        tw_addr_o         = w_tw;
        end_compute_mul_o = (w_wcnt == LAT_W'(MUL_LAT - 1));
      end
      COMPUTE_ADD_SUB: begin
        tw_addr_o     = w_tw;
        end_compute_o = (w_wcnt == LAT_W'(ADD_LAT - 1));
      end
      WRITE_RESULT_1: begin
        ram_addr_o    = w_top;
        ram_we_o      = wr_mem_i;
        tw_addr_o     = w_tw;
        end_write_1_o = wr_mem_i;
      end
      WRITE_RESULT_2: begin
        ram_addr_o = w_bot;
        ram_we_o   = wr_mem_i;
        res_sel_o  = 1'b1;
        tw_addr_o  = w_tw;
        end_algo_o = w_last_stage && w_last_bfly;
      end
      default: begin
        stage_o = '0;
        bfly_o  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Randomised bench for fft_addr_gen (N=8) against an arithmetic model of the
// FFT address schedule.
module tb_fft_addr_gen;
  import fft_fsm_pkg::*;

  localparam int N  = 8;
  localparam int LG = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  state_fsm      state_i;
  logic          en_cnt_samples_i, en_cnt_rd_i, wr_mem_i;
  logic [LG-1:0] host_addr_i;
  logic [LG-1:0] ram_addr_o, stage_o;
  logic [LG-2:0] tw_addr_o, bfly_o;
  logic ram_we_o, res_sel_o, end_samples_o, end_read_1_o, end_read_2_o;
  logic end_compute_mul_o, end_compute_o, end_write_1_o, end_algo_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_scnt, m_stage, m_bfly, m_armed, m_run;
  state_fsm m_last;

  fft_addr_gen #(.N_POINTS(N), .RD_LAT(1), .MUL_LAT(2), .ADD_LAT(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .state_i(state_i),
    .en_cnt_samples_i(en_cnt_samples_i), .en_cnt_rd_i(en_cnt_rd_i),
    .wr_mem_i(wr_mem_i), .host_addr_i(host_addr_i),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .res_sel_o(res_sel_o),
    .tw_addr_o(tw_addr_o), .stage_o(stage_o), .bfly_o(bfly_o),
    .end_samples_o(end_samples_o), .end_read_1_o(end_read_1_o),
    .end_read_2_o(end_read_2_o), .end_compute_mul_o(end_compute_mul_o),
    .end_compute_o(end_compute_o), .end_write_1_o(end_write_1_o),
    .end_algo_o(end_algo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LG; i++) r = r * 2 + ((v >> i) % 2);
    return r;
  endfunction

  task automatic model_reset();
    m_scnt = 0; m_stage = 0; m_bfly = 0; m_armed = 0; m_run = 0; m_last = IDLE;
  endtask

  task automatic check_outputs();
    int half, pos, top, wait_n;
    int e_addr, e_we, e_sel, e_tw, e_stage, e_bfly;
    int e_es, e_r1, e_r2, e_mul, e_cmp, e_w1, e_algo;
    half   = 2 ** m_stage;
    pos    = m_bfly % half;
    top    = (m_bfly / half) * 2 * half + pos;
    wait_n = (state_i == m_last) ? m_run : 0;
    e_addr = 0; e_we = 0; e_sel = 0; e_tw = pos * (N / 2) / half;
    e_stage = m_stage; e_bfly = m_bfly;
    e_es = 0; e_r1 = 0; e_r2 = 0; e_mul = 0; e_cmp = 0; e_w1 = 0; e_algo = 0;
    case (state_i)
      IDLE, DONE:      e_tw = 0;
      READ_RAM:        begin e_addr = int'(host_addr_i); e_tw = 0; end
      ACTIVE_WRITE:    begin
        e_addr = rev(m_scnt); e_we = wr_mem_i; e_tw = 0;
        e_es = (en_cnt_samples_i && m_scnt == N - 1) ? 1 : 0;
      end
      READ_1:          begin e_addr = top; e_r1 = (wait_n == 1) ? 1 : 0; end
      READ_2:          begin e_addr = top + half; e_r2 = (wait_n == 1) ? 1 : 0; end
      COMPUTE_MUL:     e_mul = (wait_n == 1) ? 1 : 0;
      COMPUTE_ADD_SUB: e_cmp = (wait_n == 0) ? 1 : 0;
      WRITE_RESULT_1:  begin e_addr = top; e_we = wr_mem_i; e_w1 = wr_mem_i; end
      WRITE_RESULT_2:  begin
        e_addr = top + half; e_we = wr_mem_i; e_sel = 1;
        e_algo = (m_stage == LG - 1 && m_bfly == N / 2 - 1) ? 1 : 0;
      end
      default:         begin e_tw = 0; e_stage = 0; e_bfly = 0; end
    endcase
    check("ram_addr", int'(ram_addr_o), e_addr);
    check("ram_we", int'(ram_we_o), e_we);
    check("res_sel", int'(res_sel_o), e_sel);
    check("tw_addr", int'(tw_addr_o), e_tw);
    check("stage", int'(stage_o), e_stage);
    check("bfly", int'(bfly_o), e_bfly);
    check("end_samples", int'(end_samples_o), e_es);
    check("end_read_1", int'(end_read_1_o), e_r1);
    check("end_read_2", int'(end_read_2_o), e_r2);
    check("end_mul", int'(end_compute_mul_o), e_mul);
    check("end_compute", int'(end_compute_o), e_cmp);
    check("end_write_1", int'(end_write_1_o), e_w1);
    check("end_algo", int'(end_algo_o), e_algo);
  endtask

  task automatic model_step();
    m_run  = ((state_i == m_last) ? m_run : 0) + 1;
    m_last = state_i;
    case (state_i)
      IDLE, DONE:     begin m_scnt = 0; m_stage = 0; m_bfly = 0; m_armed = 0; end
      ACTIVE_WRITE:   if (en_cnt_samples_i) m_scnt = (m_scnt + 1) % N;
      WRITE_RESULT_1: if (en_cnt_rd_i) m_armed = 1;
      WRITE_RESULT_2: if (m_armed != 0) begin
        m_armed = 0;
        if (m_bfly == N / 2 - 1) begin
          m_bfly  = 0;
          m_stage = (m_stage == LG - 1) ? 0 : m_stage + 1;
        end else begin
          m_bfly = m_bfly + 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input state_fsm st, input bit es, input bit er,
                       input bit wr, input int host);
    @(negedge clk_i);
    state_i = st; en_cnt_samples_i = es; en_cnt_rd_i = er; wr_mem_i = wr;
    host_addr_i = LG'(host);
    #1 check_outputs();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
  endtask

  task automatic cycle(input state_fsm st, input bit es, input bit er,
                       input bit wr, input int host);
    drive(st, es, er, wr, host);
    tick();
  endtask

  task automatic dwell(input state_fsm st, input int n);
    for (int j = 0; j < n; j++) cycle(st, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic run_fft(input bit rnd);
    int k, d;
    bit en;
    k = 0;
    while (k < N) begin
      en = rnd ? ($urandom % 4 != 0) : 1'b1;
      cycle(ACTIVE_WRITE, en, 1'b0, en, 0);
      if (en) k++;
    end
    for (int b = 0; b < (N / 2) * LG; b++) begin
      dwell(READ_1, rnd ? 1 + $urandom % 3 : 2);
      dwell(READ_2, rnd ? 1 + $urandom % 3 : 2);
      dwell(COMPUTE_MUL, rnd ? 1 + $urandom % 3 : 2);
      dwell(COMPUTE_ADD_SUB, rnd ? 1 + $urandom % 2 : 1);
      d = rnd ? 1 + $urandom % 2 : 1;
      for (int j = 0; j < d; j++) cycle(WRITE_RESULT_1, 1'b0, j == d - 1, j == d - 1, 0);
      cycle(WRITE_RESULT_2, 1'b0, 1'b0, 1'b1, 0);
    end
    drive(DONE, 1'b0, 1'b0, 1'b0, 0);
    check("done_stage", int'(stage_o), 0);
    check("done_bfly", int'(bfly_o), 0);
    tick();
    drive(READ_RAM, 1'b0, 1'b0, 1'b1, 6);
    check("host_addr", int'(ram_addr_o), 6);
    check("host_we", int'(ram_we_o), 0);
    tick();
    for (int j = 0; j < 3; j++) cycle(READ_RAM, 1'b0, 1'b0, $urandom % 2 == 1, $urandom % N);
    cycle(IDLE, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int load_tbl [8];
    load_tbl = '{0, 4, 2, 6, 1, 5, 3, 7};
    rst_ni = 1'b0;
    state_i = IDLE; en_cnt_samples_i = 1'b0; en_cnt_rd_i = 1'b0; wr_mem_i = 1'b0;
    host_addr_i = '0;
    model_reset();
    @(negedge clk_i);
    #1 check_outputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(IDLE, 1'b0, 1'b0, 1'b0, 0);

    // Reset landing in the middle of a sample load
    for (int k = 0; k < 5; k++) cycle(ACTIVE_WRITE, 1'b1, 1'b0, 1'b1, 0);
    @(negedge clk_i);
    rst_ni = 1'b0; state_i = IDLE; en_cnt_samples_i = 1'b0; wr_mem_i = 1'b0;
    model_reset();
    #1 check_outputs();
    check("rst_addr", int'(ram_addr_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(IDLE, 1'b0, 1'b0, 1'b0, 0);
    drive(ACTIVE_WRITE, 1'b0, 1'b0, 1'b0, 0);
    check("rst_scnt_addr", int'(ram_addr_o), 0);
    tick();

    // Directed load: bit-reversed addresses, end flag on the 8th sample only
    for (int k = 0; k < N; k++) begin
      drive(ACTIVE_WRITE, 1'b1, 1'b0, 1'b1, 0);
      check("load_addr", int'(ram_addr_o), load_tbl[k]);
      check("load_end", int'(end_samples_o), (k == N - 1) ? 1 : 0);
      tick();
    end
    cycle(IDLE, 1'b0, 1'b0, 1'b0, 0);

    run_fft(1'b0);
    for (int r = 0; r < 3; r++) run_fft(1'b1);

    // WRITE_RESULT_2 without a committed butterfly must not advance
    cycle(WRITE_RESULT_1, 1'b0, 1'b0, 1'b1, 0);
    cycle(WRITE_RESULT_2, 1'b0, 1'b0, 1'b1, 0);
    drive(READ_1, 1'b0, 1'b0, 1'b0, 0);
    check("unarmed_bfly", int'(bfly_o), 0);
    tick();
    cycle(WRITE_RESULT_1, 1'b0, 1'b1, 1'b1, 0);
    cycle(WRITE_RESULT_2, 1'b0, 1'b0, 1'b1, 0);
    drive(READ_1, 1'b0, 1'b0, 1'b0, 0);
    check("armed_bfly", int'(bfly_o), 1);
    tick();

    // Unencoded states: outputs quiet, counters hold
    for (int j = 0; j < 6; j++)
      cycle(state_fsm'(4'(10 + $urandom % 6)), $urandom % 2 == 1, $urandom % 2 == 1,
            $urandom % 2 == 1, $urandom % N);
    cycle(READ_2, 1'b0, 1'b0, 1'b0, 0);
    cycle(IDLE, 1'b0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_addr_gen.md
Name: fft_addr_gen

Overview:
- Address generator and sequencing-counter stage sitting directly downstream of the FFT control FSM.
- Consumes the FSM state and its enable strobes. Produces every RAM address, write enable and twiddle index for the radix-2 in-place DIT FFT.
- Returns the end-of-phase flags the FSM waits on: samples, read 1/2, mul, add/sub, write 1, and algorithm end.
- Input samples are stored bit-reversed, so results read back in natural order.

Parameters:
- N_POINTS, 16, FFT size; power of two, >= 4.
- LOG2N, $clog2(N_POINTS), number of stages; derived, not overridden.
- RD_LAT, 1, RAM read latency in cycles; >= 1.
- MUL_LAT, 2, complex multiplier latency in cycles; >= 1.
- ADD_LAT, 1, add/sub latency in cycles; >= 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- state_i  in  state_fsm  current FSM state (fft_fsm_pkg).
- en_cnt_samples_i  in  1  sample/write counter enable from the FSM.
- en_cnt_rd_i  in  1  butterfly-commit arm from the FSM.
- wr_mem_i  in  1  write request from the FSM.
- host_addr_i  in  LOG2N  host readout address, used in READ_RAM.
- ram_addr_o  out  LOG2N  RAM address.
- ram_we_o  out  1  RAM write enable.
- res_sel_o  out  1  write-data select: 0 = butterfly top output or sample, 1 = bottom output.
- tw_addr_o  out  LOG2N-1  twiddle ROM index.
- stage_o  out  LOG2N  current stage.
- bfly_o  out  LOG2N-1  current butterfly within the stage.
- end_samples_o, end_read_1_o, end_read_2_o, end_compute_mul_o, end_compute_o, end_write_1_o, end_algo_o  out  1 each  phase-end flags to the FSM.

Behaviour:
- Registers: s_cnt (LOG2N), stage (LOG2N), bfly (LOG2N-1), wcnt (wait counter, wide enough for max latency), state_q (previous state), armed (1). All reset to 0 (state_q to IDLE).
- Reset is asynchronous and may hit mid-operation. After reset all outputs are 0; end flags are 0 because state_i is IDLE.
- Output decode: all outputs are combinational from state_i, inputs and registers. No added latency, because the FSM samples the end flags in the same cycle.
- Butterfly address math:
  - span = 1<<stage; pos = bfly & (span-1); grp = bfly >> stage.
  - top = (grp << (stage+1)) | pos; bot = top + span.
  - tw_addr_o = pos << (LOG2N-1-stage).
  - tw_addr_o is 0 outside butterfly states.
- wcnt behaviour:
  - Clears whenever state_i != state_q, i.e. the first cycle of a new state sees wcnt = 0.
  - Otherwise increments with saturation.
- Per state:
  - IDLE / DONE:
    - ram_addr_o = 0, ram_we_o = 0.
    - s_cnt, stage, bfly and armed clear.
  - READ_RAM:
    - ram_addr_o = host_addr_i, ram_we_o = 0.
    - No counter changes.
  - ACTIVE_WRITE:
    - ram_addr_o = bitrev(s_cnt); ram_we_o = wr_mem_i; res_sel_o = 0.
    - s_cnt increments when en_cnt_samples_i = 1.
    - end_samples_o = en_cnt_samples_i && s_cnt == N_POINTS-1. s_cnt wraps to 0 on that cycle.
  - READ_1:
    - ram_addr_o = top.
    - end_read_1_o = (wcnt == RD_LAT).
  - READ_2:
    - ram_addr_o = bot.
    - end_read_2_o = (wcnt == RD_LAT).
  - COMPUTE_MUL: end_compute_mul_o = (wcnt == MUL_LAT-1).
  - COMPUTE_ADD_SUB: end_compute_o = (wcnt == ADD_LAT-1).
  - WRITE_RESULT_1:
    - ram_addr_o = top; ram_we_o = wr_mem_i; res_sel_o = 0.
    - end_write_1_o = wr_mem_i.
    - armed sets when en_cnt_rd_i = 1.
  - WRITE_RESULT_2:
    - ram_addr_o = bot; ram_we_o = wr_mem_i; res_sel_o = 1.
    - end_algo_o = (stage == LOG2N-1 && bfly == N_POINTS/2-1).
    - If armed, on this clock edge: bfly advances and armed clears. When bfly == N_POINTS/2-1, bfly wraps to 0 and stage increments. At the final butterfly, stage and bfly both wrap to 0.
  - WRITE_RESULT_2 without armed: error case. No advance, end_algo_o still decoded.
- The FSM stays exactly one cycle in WRITE_RESULT_2 and DONE. The block must not rely on longer dwell.
- Unknown/default state: outputs 0, counters hold.

Decomposition:
- fft_fsm_pkg (existing) is extended with a localparam for the maximum latency width and a bitrev function parameterised by width.
- state_fsm is reused, not redefined.
- One sub-module, fft_bfly_addr: purely combinational (stage, bfly) -> top, bot, tw. Instantiated once.

Test Plan:
- Reset mid-ACTIVE_WRITE (N=8): assert rst_ni low at s_cnt=5 -> all outputs 0, s_cnt=stage=bfly=0.
- N=8 load, state ACTIVE_WRITE, en=wr=1 for 8 cycles:
  - ram_addr_o sequence = 0,4,2,6,1,5,3,7 with ram_we_o=1.
  - end_samples_o=1 only on the 8th cycle.
- N=8 stage 1, bfly 3, READ_1 then READ_2 (RD_LAT=1):
  - ram_addr_o = 5 then 7, tw_addr_o = 2.
  - end_read_1_o high on the 2nd READ_1 cycle.
- N=8 stage 2, bfly 1, WRITE_RESULT_1 (en_cnt_rd=1, wr=1) then WRITE_RESULT_2:
  - Addresses 1 then 5; res_sel_o = 0 then 1; tw_addr_o = 1.
  - bfly becomes 2 afterwards.
- MUL_LAT=2, ADD_LAT=1:
  - end_compute_mul_o on the 2nd COMPUTE_MUL cycle.
  - end_compute_o on the 1st COMPUTE_ADD_SUB cycle.
- Full N=8 run (12 butterflies):
  - end_algo_o asserts only at stage=2, bfly=3 in WRITE_RESULT_2.
  - Counters return to 0; READ_RAM passes host_addr_i=6 to ram_addr_o with ram_we_o=0.
